inst_fetch: RTL and testbench



---
 rtl/inst_fetch.sv | 206 ++++++++++++++++++++
 tb/tb_inst_fetch.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch -- instruction fetch unit for the single-clock MIPS core.
//
// Purpose:
//   This block drives the word address to the instruction memory and captures
//   the combinational read data. It holds the program counter. It buffers each
//   fetched word, tagged with its byte PC, in a small show-ahead prefetch FIFO.
//   The FIFO head is presented to decode over a valid/ready handshake. A
//   redirect loads a new PC and flushes every queued entry.
//
// Ports:
//   clk             core clock, rising-edge active
//   rst_n           asynchronous, active-low reset
//   read_addr[29:0] word address to instruction memory (pc[31:2])
//   memout[31:0]    instruction word, combinational from read_addr
//   inst_valid      FIFO head holds an instruction
//   inst_ready      decode accepts the head this cycle
//   inst_out[31:0]  head instruction word
//   inst_pc[31:0]   byte PC of the head instruction
//   redirect_valid  load redirect_pc and flush the FIFO
//   redirect_pc     redirect target; bits [1:0] are ignored
//   halted          fetch stopped on a null word
//
// Parameters:
//   RESET_PC        byte address of the first fetch (word aligned)
//   FIFO_DEPTH      number of prefetch entries, a power of two from 2 to 16
//
// Configuration macro:
//   NULL_HALT_EN    When defined, an all-zero instruction word stops fetch and
//                   sets halted. When undefined, a zero word is queued like any
//                   other instruction, and halted never rises.
// -----------------------------------------------------------------------------
module inst_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0010_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [29:0] read_addr,
  input  logic [31:0] memout,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        halted
);

  localparam int              PTR_W   = $clog2(FIFO_DEPTH);
  localparam int              CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  // Architectural state.
  logic [31:0]      pc_q, pc_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q, valid_d;
  logic             halted_q, halted_d;
  logic [31:0]      head_word_q, head_word_d;
  logic [31:0]      head_pc_q, head_pc_d;

  // Entry storage. It has no reset: an entry is only ever read after it has
  // been written.
  logic [31:0]      fifo_word [FIFO_DEPTH];
  logic [31:0]      fifo_pc   [FIFO_DEPTH];

  logic             pop;
  logic             push;
  logic             space;
  logic             null_word;
  logic             halt_set;
  logic [PTR_W-1:0] rd_next_ptr;

  // The low two target bits are deliberately discarded (word-aligned fetch).
  logic             unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // ---------------------------------------------------------------------------
  // Null-word detection
  // ---------------------------------------------------------------------------
  always_comb begin
    null_word = 1'b0;
`ifdef NULL_HALT_EN
    null_word = (memout == 32'h0000_0000);
`else
    null_word = 1'b0;
`endif
  end

  // ---------------------------------------------------------------------------
  // Handshake and push qualification
  // ---------------------------------------------------------------------------
  assign pop         = valid_q & inst_ready;
  // A full FIFO still has room when the head leaves in the same cycle.
  assign space       = (count_q < DEPTH_C) | pop;
  assign push        = ~halted_q & ~redirect_valid & space & ~null_word;
  assign halt_set    = ~halted_q & ~redirect_valid & space & null_word;
  assign rd_next_ptr = rd_ptr_q + PTR_W'(1);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_d        = pc_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    halted_d    = halted_q;
    head_word_d = head_word_q;
    head_pc_d   = head_pc_q;

    if (redirect_valid) begin
      // A redirect outranks everything else: it drops a same-cycle pop and
      // suppresses the push. The head registers keep their stale contents
      // because decode ignores them while inst_valid is low.
      pc_d     = {redirect_pc[31:2], 2'b00};
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      halted_d = 1'b0;
    end else begin
      if (pop) begin
        rd_ptr_d = rd_next_ptr;
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        pc_d     = pc_q + 32'd4;
      end
      if (halt_set) begin
        halted_d = 1'b1;
      end

      unique case ({push, pop})
        2'b10:   count_d = count_q + ONE_C;
        2'b01:   count_d = count_q - ONE_C;
        default: count_d = count_q;
      endcase

      // The head registers track the oldest live entry, so the outputs never
      // depend on memout. If the FIFO is empty, or holds only the entry that is
      // leaving, the word being pushed becomes the new head directly.
      if (pop) begin
        if (count_q > ONE_C) begin
          head_word_d = fifo_word[rd_next_ptr];
          head_pc_d   = fifo_pc[rd_next_ptr];
        end else if (push) begin
          head_word_d = memout;
          head_pc_d   = pc_q;
        end
      end else if ((count_q == '0) && push) begin
        head_word_d = memout;
        head_pc_d   = pc_q;
      end
    end

    valid_d = (count_d != '0);
  end

  // ---------------------------------------------------------------------------
  // Control and head registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      valid_q     <= 1'b0;
      halted_q    <= 1'b0;
      head_word_q <= 32'h0;
      head_pc_q   <= 32'h0;
    end else begin
      pc_q        <= pc_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      valid_q     <= valid_d;
      halted_q    <= halted_d;
      head_word_q <= head_word_d;
      head_pc_q   <= head_pc_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Entry storage write port
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_word[wr_ptr_q] <= memout;
      fifo_pc[wr_ptr_q]   <= pc_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign read_addr  = pc_q[31:2];
  assign inst_valid = valid_q;
  assign inst_out   = head_word_q;
  assign inst_pc    = head_pc_q;
  assign halted     = halted_q;

endmodule

// File: tb/tb_inst_fetch.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch -- self-checking bench for inst_fetch.
//
// A queue-based model tracks the expected PC, the buffered {pc, word} entries
// and the halt flag. The instruction memory image is generated as follows:
//   word(i) = 0x20080001 + i * 0x00010001
// where i is the word offset from 0x00100000. When zero_img is set, the word
// at 0x0010000C reads as zero instead.
// -----------------------------------------------------------------------------
module tb_inst_fetch;

  localparam logic [31:0] BASE    = 32'h0010_0000;
  localparam int          DEPTH   = 4;
  localparam logic [29:0] BASE_WA = 30'(32'h0010_0000 >> 2);
  localparam logic [29:0] NULL_WA = 30'(32'h0010_000C >> 2);
`ifdef NULL_HALT_EN
  localparam bit NULL_EN = 1'b1;
`else
  localparam bit NULL_EN = 1'b0;
`endif

  logic        clk            = 1'b0;
  logic        rst_n          = 1'b1;
  logic [29:0] read_addr;
  logic [31:0] memout;
  logic        inst_valid;
  logic        inst_ready     = 1'b0;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc    = 32'h0;
  logic        halted;

  int checks = 0;
  int errors = 0;
  bit zero_img = 1'b0;

  // Reference model state.
  logic [63:0] q[$];
  logic [31:0] m_pc;
  bit          m_halted;
  logic [63:0] exp_h;

  inst_fetch #(.RESET_PC(BASE), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .read_addr      (read_addr),
    .memout         (memout),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_out       (inst_out),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [29:0] wa, input bit z);
    logic [31:0] idx;
    if (z && (wa == NULL_WA)) return 32'h0;
    idx = 32'(wa) - 32'(BASE_WA);
    return 32'h2008_0001 + (idx << 16) + idx;
  endfunction

  always_comb memout = mem_word(read_addr, zero_img);

  // Apply one clock edge to the model, using the inputs currently driven. The
  // task then moves on to the next sampling point (the falling edge).
  task automatic advance();
    bit          pop;
    bit          space;
    bit          nullw;
    logic [31:0] w;
    pop   = (q.size() != 0) && inst_ready;
    space = (q.size() < DEPTH) || pop;
    w     = mem_word(m_pc[31:2], zero_img);
    nullw = NULL_EN && (w == 32'h0);
    if (redirect_valid) begin
      q.delete();
      m_pc     = {redirect_pc[31:2], 2'b00};
      m_halted = 1'b0;
    end else begin
      if (pop) void'(q.pop_front());
      if (!m_halted && space) begin
        if (nullw) m_halted = 1'b1;
        else begin
          q.push_back({m_pc, w});
          m_pc = m_pc + 32'd4;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_reset();
    q.delete();
    m_pc     = BASE;
    m_halted = 1'b0;
  endtask

  task automatic apply_reset();
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    rst_n          = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (inst_valid !== 1'b0 || inst_out !== 32'h0 || inst_pc !== 32'h0 ||
        read_addr !== BASE_WA || halted !== 1'b0) begin
      errors++;
      $display("FAIL reset valid=%b out=%h pc=%h addr=%h halted=%b required 0/0/0/%h/0",
               inst_valid, inst_out, inst_pc, read_addr, halted, BASE_WA);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    $display("reset: valid=%b addr=%h", inst_valid, read_addr);
  endtask

  task automatic test_stream();
    apply_reset();
    zero_img   = 1'b0;
    inst_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      exp_h = (q.size() != 0) ? q[0] : 64'h0;
      checks++;
      if (inst_valid !== (q.size() != 0) || read_addr !== m_pc[31:2] || halted !== m_halted ||
          (q.size() != 0 && {inst_pc, inst_out} !== exp_h)) begin
        errors++;
        $display("FAIL stream cyc=%0d valid=%b addr=%h pc=%h word=%h required valid=%b addr=%h head=%h",
                 i, inst_valid, read_addr, inst_pc, inst_out, q.size() != 0, m_pc[31:2], exp_h);
      end
      if (i == 1) begin
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== BASE || inst_out !== 32'h2008_0001) begin
          errors++;
          $display("FAIL first_fetch valid=%b pc=%h word=%h required 1/%h/20080001",
                   inst_valid, inst_pc, inst_out, BASE);
        end
      end
      $display("stream cyc=%0d valid=%b pc=%h word=%h", i, inst_valid, inst_pc, inst_out);
      advance();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] got[$];
    int          bad;
    apply_reset();
    zero_img   = 1'b0;
    inst_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      exp_h = (q.size() != 0) ? q[0] : 64'h0;
      checks++;
      if (inst_valid !== (q.size() != 0) || read_addr !== m_pc[31:2] ||
          (q.size() != 0 && {inst_pc, inst_out} !== exp_h)) begin
        errors++;
        $display("FAIL backpressure cyc=%0d valid=%b addr=%h pc=%h required valid=%b addr=%h head=%h",
                 i, inst_valid, read_addr, inst_pc, q.size() != 0, m_pc[31:2], exp_h);
      end
      advance();
    end
    checks++;
    if (read_addr !== 30'(32'h0010_0010 >> 2)) begin
      errors++;
      $display("FAIL bp_freeze addr=%h required %h", read_addr, 30'(32'h0010_0010 >> 2));
    end
    $display("backpressure: frozen addr=%h model_count=%0d", read_addr, q.size());
    inst_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      exp_h = (q.size() != 0) ? q[0] : 64'h0;
      checks++;
      if (inst_valid !== (q.size() != 0) || read_addr !== m_pc[31:2] ||
          (q.size() != 0 && {inst_pc, inst_out} !== exp_h)) begin
        errors++;
        $display("FAIL bp_release cyc=%0d valid=%b addr=%h pc=%h required valid=%b addr=%h head=%h",
                 i, inst_valid, read_addr, inst_pc, q.size() != 0, m_pc[31:2], exp_h);
      end
      if (inst_valid === 1'b1) got.push_back(inst_pc);
      advance();
    end
    bad = 0;
    foreach (got[k]) if (got[k] !== BASE + 32'(4 * k)) bad++;
    checks++;
    if (bad != 0 || got.size() != 12) begin
      errors++;
      $display("FAIL bp_order delivered=%0d out_of_order=%0d required 12/0", got.size(), bad);
    end
  endtask

  task automatic test_redirect();
    apply_reset();
    zero_img   = 1'b0;
    inst_ready = 1'b0;
    repeat (3) advance();
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== BASE) begin
      errors++;
      $display("FAIL redir_pre valid=%b pc=%h required 1/%h", inst_valid, inst_pc, BASE);
    end
    inst_ready     = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0010_0043;
    advance();
    redirect_valid = 1'b0;
    checks++;
    if (inst_valid !== 1'b0 || read_addr !== 30'(32'h0010_0040 >> 2)) begin
      errors++;
      $display("FAIL redir_flush valid=%b addr=%h required 0/%h",
               inst_valid, read_addr, 30'(32'h0010_0040 >> 2));
    end
    advance();
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h0010_0040 || inst_out !== mem_word(30'(32'h0010_0040 >> 2), 1'b0)) begin
      errors++;
      $display("FAIL redir_target valid=%b pc=%h word=%h required 1/00100040", inst_valid, inst_pc, inst_out);
    end
    $display("redirect: valid=%b pc=%h", inst_valid, inst_pc);
  endtask

  task automatic test_null();
    logic [31:0] pcs[$];
    logic [31:0] words[$];
    int          seen_zero;
    apply_reset();
    zero_img   = 1'b1;
    inst_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      exp_h = (q.size() != 0) ? q[0] : 64'h0;
      checks++;
      if (inst_valid !== (q.size() != 0) || read_addr !== m_pc[31:2] || halted !== m_halted ||
          (q.size() != 0 && {inst_pc, inst_out} !== exp_h)) begin
        errors++;
        $display("FAIL null cyc=%0d valid=%b addr=%h halted=%b pc=%h required valid=%b addr=%h halted=%b head=%h",
                 i, inst_valid, read_addr, halted, inst_pc, q.size() != 0, m_pc[31:2], m_halted, exp_h);
      end
      if (inst_valid === 1'b1) begin
        pcs.push_back(inst_pc);
        words.push_back(inst_out);
      end
      advance();
    end
    $display("null: delivered=%0d halted=%b addr=%h", pcs.size(), halted, read_addr);
`ifdef NULL_HALT_EN
    checks++;
    if (pcs.size() != 3 || halted !== 1'b1 || inst_valid !== 1'b0 || read_addr !== NULL_WA) begin
      errors++;
      $display("FAIL null_halt delivered=%0d halted=%b valid=%b addr=%h required 3/1/0/%h",
               pcs.size(), halted, inst_valid, read_addr, NULL_WA);
    end
    redirect_valid = 1'b1;
    redirect_pc    = BASE;
    advance();
    redirect_valid = 1'b0;
    advance();
    checks++;
    if (halted !== 1'b0 || inst_valid !== 1'b1 || inst_pc !== BASE) begin
      errors++;
      $display("FAIL null_resume halted=%b valid=%b pc=%h required 0/1/%h", halted, inst_valid, inst_pc, BASE);
    end
`else
    seen_zero = 0;
    foreach (pcs[k]) if (pcs[k] === 32'h0010_000C && words[k] === 32'h0) seen_zero++;
    checks++;
    if (seen_zero != 1 || halted !== 1'b0) begin
      errors++;
      $display("FAIL null_pass zero_delivered=%0d halted=%b required 1/0", seen_zero, halted);
    end
`endif
    zero_img = 1'b0;
  endtask

  task automatic test_async_reset();
    apply_reset();
    zero_img   = 1'b0;
    inst_ready = 1'b0;
    repeat (2) advance();
    checks++;
    if (inst_valid !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre valid=%b required 1", inst_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (inst_valid !== 1'b0 || read_addr !== BASE_WA || inst_pc !== 32'h0) begin
      errors++;
      $display("FAIL areset valid=%b addr=%h pc=%h required 0/%h/0", inst_valid, read_addr, inst_pc, BASE_WA);
    end
    $display("async_reset: valid=%b addr=%h", inst_valid, read_addr);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_random();
    apply_reset();
    zero_img = 1'($urandom_range(0, 1));
    for (int i = 0; i < 400; i++) begin
      inst_ready     = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = BASE + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
      exp_h = (q.size() != 0) ? q[0] : 64'h0;
      checks++;
      if (inst_valid !== (q.size() != 0) || read_addr !== m_pc[31:2] || halted !== m_halted ||
          (q.size() != 0 && {inst_pc, inst_out} !== exp_h)) begin
        errors++;
        $display("FAIL random cyc=%0d valid=%b addr=%h halted=%b pc=%h word=%h required valid=%b addr=%h halted=%b head=%h",
                 i, inst_valid, read_addr, halted, inst_pc, inst_out, q.size() != 0, m_pc[31:2], m_halted, exp_h);
      end
      advance();
    end
    redirect_valid = 1'b0;
    $display("random: 400 cycles zero_img=%b", zero_img);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_null();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1);
  end

endmodule
